// File: rtl/uart_clk_pkg.sv
// Shared types and constants for the UART baud-clock arbiter.
// Imported by the top-level arbiter and the round-robin pick.
package uart_clk_pkg;

    localparam int N_CLIENTS = 2;
    localparam int DIV_W     = 3;
    localparam int CFG_W     = 1 + DIV_W;
    localparam int IDX_W     = $clog2(N_CLIENTS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_e;

    typedef struct packed {
        logic             freq;
        logic [DIV_W-1:0] div;
    } clk_cfg_t;

endpackage

// File: rtl/uart_clk_rr_arb.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the client named by the pointer. Purely combinational.
module uart_clk_rr_arb
    import uart_clk_pkg::*;
(
    input  logic [N_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [N_CLIENTS-1:0] winner
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        winner = '0;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = (ptr == IDX_W'(1)) ? 2'b10 : 2'b01;
            default: winner = '0;
        endcase
    end

endmodule

// File: rtl/uart_clk_arb.sv
// Arbitrates one shared baud-clock generator between two UART clients,
// holding it disabled for SETTLE_CYCLES after every configuration change.
module uart_clk_arb
    import uart_clk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter bit ALLOW_SHARE   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CLIENTS-1:0]       req,
    input  logic [N_CLIENTS-1:0]       cfg_freq,
    input  logic [N_CLIENTS*DIV_W-1:0] cfg_div,
    output logic [N_CLIENTS-1:0]       gnt,
    output logic                       gen_en,
    output logic                       gen_freq,
    output logic [DIV_W-1:0]           gen_div,
    output logic                       busy
);

    localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e                 state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [N_CLIENTS-1:0]   gnt_q,     gnt_d;
    clk_cfg_t               gen_cfg_q, gen_cfg_d;
    logic [IDX_W-1:0]       owner_q,   owner_d;
    logic [IDX_W-1:0]       ptr_q,     ptr_d;

    clk_cfg_t               cli_cfg [N_CLIENTS];
    logic [N_CLIENTS-1:0]   winner;
    logic [N_CLIENTS-1:0]   held;
    logic [N_CLIENTS-1:0]   join_ok;
    logic [IDX_W-1:0]       last_idx;

    uart_clk_rr_arb u_rr_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner)
    );

    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            cli_cfg[i].freq = cfg_freq[i];
            cli_cfg[i].div  = cfg_div[DIV_W*i +: DIV_W];
        end
    end

    // A waiting client may join a running grant only with an identical configuration.
    always_comb begin
        held    = gnt_q & req;
        join_ok = '0;
        for (int j = 0; j < N_CLIENTS; j++) begin
            join_ok[j] = ALLOW_SHARE && !gnt_q[j] && req[j] && (cli_cfg[j] == gen_cfg_q);
        end
    end

    // The client still holding the clock when RUN ends; a joint release credits the original owner.
    always_comb begin
        case (gnt_q)
            2'b01:   last_idx = IDX_W'(0);
            2'b10:   last_idx = IDX_W'(1);
            default: last_idx = owner_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gen_cfg_d = gen_cfg_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|winner) begin
                    for (int i = 0; i < N_CLIENTS; i++) begin
                        if (winner[i]) begin
                            gen_cfg_d = cli_cfg[i];
                            owner_d   = IDX_W'(i);
                        end
                    end
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                gnt_d = '0;
                if (!req[owner_q]) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    gnt_d[owner_q] = 1'b1;
                    state_d        = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RUN: begin
                if (held == '0) begin
                    gnt_d   = '0;
                    ptr_d   = last_idx + IDX_W'(1);
                    state_d = IDLE;
                end else begin
                    gnt_d = held | join_ok;
                end
            end

            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt_q     <= '0;
            gen_cfg_q <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gen_cfg_q <= gen_cfg_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt      = gnt_q;
    assign gen_en   = (state_q == RUN);
    assign gen_freq = gen_cfg_q.freq;
    assign gen_div  = gen_cfg_q.div;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_clk_arb.sv
// Directed bench for uart_clk_arb: latency, handover gap, sharing, mismatch,
// SETTLE abort and mid-RUN reset, with hand-computed expectations.
module tb_uart_clk_arb;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] cfg_freq;
    logic [5:0] cfg_div;

    logic [1:0] gnt,    ns_gnt;
    logic       gen_en, ns_gen_en;
    logic       gen_freq, ns_gen_freq;
    logic [2:0] gen_div,  ns_gen_div;
    logic       busy,   ns_busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_clk_arb #(.SETTLE_CYCLES(4), .ALLOW_SHARE(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .cfg_freq (cfg_freq),
        .cfg_div  (cfg_div),
        .gnt      (gnt),
        .gen_en   (gen_en),
        .gen_freq (gen_freq),
        .gen_div  (gen_div),
        .busy     (busy)
    );

    uart_clk_arb #(.SETTLE_CYCLES(4), .ALLOW_SHARE(1'b0)) dut_ns (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .cfg_freq (cfg_freq),
        .cfg_div  (cfg_div),
        .gnt      (ns_gnt),
        .gen_en   (ns_gen_en),
        .gen_freq (ns_gen_freq),
        .gen_div  (ns_gen_div),
        .busy     (ns_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        req = 2'b00;
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    int low;

    initial begin
        rst      = 1'b0;
        req      = 2'b00;
        cfg_freq = 2'b00;
        cfg_div  = 6'd0;

        // Reset state
        do_reset();
        check("rst_gnt",    32'(gnt),      32'h0);
        check("rst_en",     32'(gen_en),   32'h0);
        check("rst_freq",   32'(gen_freq), 32'h0);
        check("rst_div",    32'(gen_div),  32'h0);
        check("rst_busy",   32'(busy),     32'h0);

        // 1: single request latency, cfg0=(1,3)
        cfg_freq = 2'b01;
        cfg_div  = {3'd0, 3'd3};
        req      = 2'b01;
        step();
        check("t1_freq",    32'(gen_freq), 32'h1);
        check("t1_div",     32'(gen_div),  32'h3);
        check("t1_busy",    32'(busy),     32'h1);
        check("t1_en_e0",   32'(gen_en),   32'h0);
        steps(3);
        check("t1_en_e3",   32'(gen_en),   32'h0);
        check("t1_gnt_e3",  32'(gnt),      32'h0);
        step();
        check("t1_en_e4",   32'(gen_en),   32'h1);
        check("t1_gnt_e4",  32'(gnt),      32'h1);
        req = 2'b00;
        step();
        check("t1_rel_gnt", 32'(gnt),      32'h0);
        check("t1_rel_en",  32'(gen_en),   32'h0);
        check("t1_rel_bsy", 32'(busy),     32'h0);

        // 2: both request from reset, handover gap
        do_reset();
        cfg_freq = 2'b10;
        cfg_div  = {3'd5, 3'd1};
        req      = 2'b11;
        step();
        check("t2_freq0",   32'(gen_freq), 32'h0);
        check("t2_div0",    32'(gen_div),  32'h1);
        steps(4);
        check("t2_gnt0",    32'(gnt),      32'h1);
        check("t2_en0",     32'(gen_en),   32'h1);
        req = 2'b10;
        step();
        check("t2_rel_gnt", 32'(gnt),      32'h0);
        check("t2_rel_en",  32'(gen_en),   32'h0);
        low = 1;
        for (int i = 0; i < 20 && !gen_en; i++) begin
            step();
            if (!gen_en) low++;
        end
        check("t2_gap",     32'(low),      32'd5);
        check("t2_gnt1",    32'(gnt),      32'h2);
        check("t2_freq1",   32'(gen_freq), 32'h1);
        check("t2_div1",    32'(gen_div),  32'h5);
        req = 2'b00;
        step();

        // 3: matching cfg shares the running clock
        do_reset();
        cfg_freq = 2'b00;
        cfg_div  = {3'd2, 3'd2};
        req      = 2'b01;
        steps(5);
        check("t3_gnt0",    32'(gnt),      32'h1);
        req = 2'b11;
        step();
        check("t3_share",   32'(gnt),      32'h3);
        check("t3_en_sh",   32'(gen_en),   32'h1);
        req = 2'b10;
        step();
        check("t3_keep1",   32'(gnt),      32'h2);
        check("t3_en_k",    32'(gen_en),   32'h1);
        check("t3_busy",    32'(busy),     32'h1);
        steps(2);
        check("t3_hold",    32'(gnt),      32'h2);
        req = 2'b00;
        step();
        check("t3_end",     32'(busy),     32'h0);

        // 4: mismatching cfg waits for the RUN to end
        do_reset();
        cfg_freq = 2'b10;
        cfg_div  = {3'd0, 3'd2};
        req      = 2'b01;
        steps(5);
        check("t4_gnt0",    32'(gnt),      32'h1);
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_wait",  32'(gnt),      32'h1);
        end
        req = 2'b10;
        step();
        check("t4_idle_g",  32'(gnt),      32'h0);
        check("t4_idle_b",  32'(busy),     32'h0);
        step();
        check("t4_st_bsy",  32'(busy),     32'h1);
        check("t4_freq",    32'(gen_freq), 32'h1);
        check("t4_div",     32'(gen_div),  32'h0);
        check("t4_st_en",   32'(gen_en),   32'h0);
        steps(4);
        check("t4_gnt1",    32'(gnt),      32'h2);
        check("t4_en1",     32'(gen_en),   32'h1);
        req = 2'b00;
        step();

        // 5: abort in the second SETTLE cycle, pointer unchanged
        do_reset();
        cfg_freq = 2'b01;
        cfg_div  = {3'd0, 3'd6};
        req      = 2'b01;
        step();
        check("t5_settle",  32'(busy),     32'h1);
        step();
        req = 2'b00;
        step();
        check("t5_ab_bsy",  32'(busy),     32'h0);
        for (int i = 0; i < 5; i++) begin
            check("t5_ab_en",  32'(gen_en), 32'h0);
            check("t5_ab_gnt", 32'(gnt),    32'h0);
            step();
        end
        cfg_freq = 2'b00;
        cfg_div  = {3'd7, 3'd1};
        req      = 2'b11;
        step();
        check("t5_div",     32'(gen_div),  32'h1);
        steps(4);
        check("t5_gnt0",    32'(gnt),      32'h1);
        req = 2'b00;
        step();

        // 6: no sharing when disabled; reset mid-RUN
        do_reset();
        cfg_freq = 2'b11;
        cfg_div  = {3'd3, 3'd3};
        req      = 2'b10;
        steps(5);
        check("t6_ns_gnt1", 32'(ns_gnt),   32'h2);
        req = 2'b11;
        step();
        check("t6_noshare", 32'(ns_gnt),   32'h2);
        check("t6_share",   32'(gnt),      32'h3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t6_rst_gnt", 32'(ns_gnt),      32'h0);
        check("t6_rst_en",  32'(ns_gen_en),   32'h0);
        check("t6_rst_frq", 32'(ns_gen_freq), 32'h0);
        check("t6_rst_div", 32'(ns_gen_div),  32'h0);
        check("t6_rst_bsy", 32'(ns_busy),     32'h0);
        step();
        check("t6_freq",    32'(ns_gen_freq), 32'h1);
        check("t6_div",     32'(ns_gen_div),  32'h3);
        steps(4);
        check("t6_gnt0",    32'(ns_gnt),      32'h1);
        check("t6_en",      32'(ns_gen_en),   32'h1);
        req = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
